// File: rtl/sqrt_scheduler_if.sv
// rtl/sqrt_scheduler_if.sv - requester/result bundle for the shared square-root scheduler
//   req_valid  [NREQ]       requester i has a radicand pending
//   req_data   [NREQ*NBITS] radicand of requester i at [i*NBITS +: NBITS]
//   req_ready  [NREQ]       one-hot grant
//   busy                    engine occupied
//   res_valid  [NREQ]       one-hot single-cycle result strobe
//   res_answer [MBITS]      floor(sqrt(radicand)), held until next result
interface sqrt_scheduler_if #(
    parameter int NBITS = 21,
    parameter int MBITS = (NBITS + 1) / 2,
    parameter int NREQ  = 3
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*NBITS-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  busy;
    logic [NREQ-1:0]       res_valid;
    logic [MBITS-1:0]      res_answer;

    modport master (
        output req_valid, req_data,
        input  req_ready, busy, res_valid, res_answer
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, busy, res_valid, res_answer
    );
endinterface

// File: rtl/sqrt_scheduler.sv
// rtl/sqrt_scheduler.sv - round-robin scheduler sharing one bit-serial integer square-root engine
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      sqrt_scheduler_if.slave: requests in, grants/results out
//   Optional (macro SQRT_SCHED_STATS_EN):
//     ops_done[15:0]     wrapping count of result strobes
//     stall_cycles[15:0] saturating count of cycles with a valid request but no handshake
module sqrt_scheduler #(
    parameter int NBITS = 21,
    parameter int MBITS = (NBITS + 1) / 2,
    parameter int NREQ  = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    sqrt_scheduler_if.slave   bus
`ifdef SQRT_SCHED_STATS_EN
    ,
    output logic [15:0]       ops_done,
    output logic [15:0]       stall_cycles
`endif
);
    localparam int IW  = $clog2(NREQ);
    localparam int BW  = (MBITS > 1) ? $clog2(MBITS) : 1;
    localparam int SQW = 2 * MBITS;

    typedef enum logic [1:0] {IDLE, BUSY, RESULT} state_t;

    state_t            state;
    logic [IW-1:0]     last;
    logic [IW-1:0]     tag;
    logic [NBITS-1:0]  radicand;
    logic [MBITS-1:0]  answer;
    logic [BW-1:0]     bitc;
    logic              busy_q;
    logic [NREQ-1:0]   res_valid_q;
    logic [MBITS-1:0]  res_answer_q;

    // Round-robin winner: first valid requester scanning from last+1.
    logic              win_found;
    logic [IW-1:0]     win_idx;
    int                cand;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(last) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!win_found && bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = IW'(cand);
            end
        end
    end

    logic              handshake;
    logic [NBITS-1:0]  sel_data;

    assign handshake     = (state == IDLE) && win_found;
    assign sel_data      = bus.req_data[win_idx*NBITS +: NBITS];
    assign bus.req_ready = handshake ? (NREQ'(1) << win_idx) : '0;

    // One answer bit per cycle; the square is kept at full 2*MBITS width so
    // the all-ones radicand cannot overflow the comparison.
    logic [MBITS-1:0]  trial;
    logic [SQW-1:0]    trial_sq;
    logic [MBITS-1:0]  next_answer;

    always_comb begin
        trial       = answer | (MBITS'(1) << bitc);
        trial_sq    = SQW'(trial) * SQW'(trial);
        next_answer = (trial_sq <= SQW'(radicand)) ? trial : answer;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            last         <= IW'(NREQ - 1);
            tag          <= '0;
            radicand     <= '0;
            answer       <= '0;
            bitc         <= '0;
            busy_q       <= 1'b0;
            res_valid_q  <= '0;
            res_answer_q <= '0;
        end else begin
            res_valid_q <= '0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        radicand <= sel_data;
                        tag      <= win_idx;
                        last     <= win_idx;
                        answer   <= '0;
                        bitc     <= BW'(MBITS - 1);
                        busy_q   <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    answer <= next_answer;
                    if (bitc == '0) begin
                        res_answer_q <= next_answer;
                        res_valid_q  <= NREQ'(1) << tag;
                        state        <= RESULT;
                    end else begin
                        bitc <= bitc - 1'b1;
                    end
                end
                RESULT: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_answer = res_answer_q;

`ifdef SQRT_SCHED_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ops_done     <= '0;
            stall_cycles <= '0;
        end else begin
            if (|res_valid_q) ops_done <= ops_done + 16'd1;
            if ((|bus.req_valid) && !handshake && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_sqrt_scheduler.sv
// tb/tb_sqrt_scheduler.sv - self-checking bench for sqrt_scheduler
module tb_sqrt_scheduler;
    localparam int NBITS = 21;
    localparam int MBITS = 11;
    localparam int NREQ  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sqrt_scheduler_if #(.NBITS(NBITS), .MBITS(MBITS), .NREQ(NREQ)) bus();

    logic [NREQ-1:0]  v;
    logic [NBITS-1:0] d [NREQ];

    assign bus.req_valid = v;
    for (genvar g = 0; g < NREQ; g++) begin : g_data
        assign bus.req_data[g*NBITS +: NBITS] = d[g];
    end

`ifdef SQRT_SCHED_STATS_EN
    logic [15:0] ops_done, stall_cycles;
`endif

    sqrt_scheduler #(.NBITS(NBITS), .MBITS(MBITS), .NREQ(NREQ)) dut (
        .clk(clk),
        .reset_n(rst_n),
        .bus(bus)
`ifdef SQRT_SCHED_STATS_EN
        ,
        .ops_done(ops_done),
        .stall_cycles(stall_cycles)
`endif
    );

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic longint isqrt(input longint x);
        longint r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic int rr_winner(input logic [NREQ-1:0] vv, input int lst);
        for (int k = 1; k <= NREQ; k++) begin
            int idx = (lst + k) % NREQ;
            if (vv[idx]) return idx;
        end
        return -1;
    endfunction

    // Behavioural model: m_cnt = cycles since grant (0 = engine free).
    int     m_last, m_cnt, m_tag, m_ops, m_stall;
    longint m_data, m_res;

    task automatic m_reset();
        m_last = NREQ - 1; m_cnt = 0; m_tag = 0;
        m_data = 0; m_res = 0; m_ops = 0; m_stall = 0;
    endtask

    initial begin
        int w;
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_reset();
            end else begin
                w = (m_cnt == 0) ? rr_winner(v, m_last) : -1;
                if ((|v) && w < 0 && m_stall < 65535) m_stall++;
                if (m_cnt == MBITS + 1) begin
                    m_ops = (m_ops + 1) & 16'hFFFF;
                    m_cnt = 0;
                end else if (m_cnt > 0) begin
                    m_cnt++;
                    if (m_cnt == MBITS + 1) m_res = isqrt(m_data);
                end else if (w >= 0) begin
                    m_tag = w; m_last = w; m_data = longint'(d[w]); m_cnt = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        int w;
        logic [NREQ-1:0] exp_ready, exp_rv;
        forever begin
            @(negedge clk);
            w = (m_cnt == 0) ? rr_winner(v, m_last) : -1;
            exp_ready = (w >= 0) ? (NREQ'(1) << w) : '0;
            exp_rv    = (m_cnt == MBITS + 1) ? (NREQ'(1) << m_tag) : '0;
            chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
            chk("busy", 64'(bus.busy), 64'(m_cnt != 0));
            chk("res_valid", 64'(bus.res_valid), 64'(exp_rv));
            chk("res_answer", 64'(bus.res_answer), 64'(m_res));
`ifdef SQRT_SCHED_STATS_EN
            chk("ops_done", 64'(ops_done), 64'(m_ops));
            chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif
        end
    end

    int res1_cnt = 0;
    initial forever begin
        @(negedge clk);
        if (bus.res_valid[1]) res1_cnt++;
    end

    task automatic wait_res(output int tag, output int ans, output int at);
        bit found = 0;
        tag = -1; ans = -1; at = -1;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            if (|bus.res_valid) begin
                found = 1;
                for (int i = 0; i < NREQ; i++) if (bus.res_valid[i]) tag = i;
                ans = int'(bus.res_answer);
                at  = int'($time / 10);
            end
        end
        if (!found) begin
            n_checks++; n_err++;
            $display("FAIL wait_res: no res_valid within 60 cycles, got 0 expected 1");
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40 && m_cnt != 0; k++) @(negedge clk);
        @(posedge clk); #2;
    endtask

    task automatic run_single(input int data, input int exp_ans);
        int k;
        bit found;
        wait_idle();
        d[0] = NBITS'(data); v = 3'b001;
        @(posedge clk); #2;
        v = 3'b000;
        k = 0; found = 0;
        while (k < 40 && !found) begin
            @(negedge clk); k++;
            if (bus.res_valid != 0) found = 1;
        end
        chk("single_latency", 64'(k - 1), 64'(MBITS));
        chk("single_tag", 64'(bus.res_valid), 64'(3'b001));
        chk("single_answer", 64'(bus.res_answer), 64'(exp_ans));
        @(negedge clk);
        chk("single_busy_after", 64'(bus.busy), 64'(0));
    endtask

    initial begin
        int tag, ans, at, prev_at, base1;
        int exp_tag [4] = '{0, 1, 2, 0};
        int exp_ans [4] = '{3, 4, 5, 3};
        v = '0;
        for (int i = 0; i < NREQ; i++) d[i] = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;

        // Three requesters held: rotating grants 13 cycles apart.
        d[0] = 9; d[1] = 16; d[2] = 25; v = 3'b111;
        prev_at = 0;
        for (int r = 0; r < 4; r++) begin
            wait_res(tag, ans, at);
            chk("rr_tag", 64'(tag), 64'(exp_tag[r]));
            chk("rr_answer", 64'(ans), 64'(exp_ans[r]));
            if (r > 0) chk("rr_spacing", 64'(at - prev_at), 64'(MBITS + 2));
            prev_at = at;
        end
        @(posedge clk); #2 v = 3'b000;
`ifdef SQRT_SCHED_STATS_EN
        @(negedge clk);
        chk("ops_done_after_rr", 64'(ops_done), 64'(4));
`endif

        run_single(1000000, 1000);
        run_single(0, 0);
        run_single(2097151, 1448);
        run_single(1048575, 1023);
        run_single(1048576, 1024);

        // Requester 1 withdraws before its grant; requester 2 is served next.
        wait_idle();
        d[0] = 49; v = 3'b001;
        @(posedge clk); #2 v = 3'b000;
        repeat (3) @(posedge clk);
        #2 d[1] = 100; d[2] = 144; v = 3'b110;
        repeat (5) @(posedge clk);
        #2 v[1] = 1'b0;
        base1 = res1_cnt;
        wait_res(tag, ans, at);
        chk("drop_first_tag", 64'(tag), 64'(0));
        chk("drop_first_answer", 64'(ans), 64'(7));
        wait_res(tag, ans, at);
        chk("drop_next_tag", 64'(tag), 64'(2));
        chk("drop_next_answer", 64'(ans), 64'(12));
        @(posedge clk); #2 v = 3'b000;
        repeat (3) @(posedge clk);
        chk("drop_no_res1", 64'(res1_cnt - base1), 64'(0));

        // Reset in the middle of an operation.
        wait_idle();
        d[0] = 400; v = 3'b001;
        @(posedge clk); #2 v = 3'b000;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_res_valid", 64'(bus.res_valid), 64'(0));
        chk("rst_res_answer", 64'(bus.res_answer), 64'(0));
        chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
        @(posedge clk); #2 rst_n = 1'b1;
        begin
            int pulses = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (|bus.res_valid) pulses++;
            end
            chk("rst_discarded_op", 64'(pulses), 64'(0));
        end
        @(posedge clk); #2;
        d[0] = 36; d[1] = 64; v = 3'b011;
        wait_res(tag, ans, at);
        chk("post_rst_tag", 64'(tag), 64'(0));
        chk("post_rst_answer", 64'(ans), 64'(6));
        wait_res(tag, ans, at);
        chk("post_rst_tag2", 64'(tag), 64'(1));
        chk("post_rst_answer2", 64'(ans), 64'(8));
        @(posedge clk); #2 v = 3'b000;

        // Randomised traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #2;
            for (int i = 0; i < NREQ; i++) begin
                if (v[i]) begin
                    if ($urandom_range(15) == 0) v[i] = 1'b0;
                end else begin
                    case ($urandom_range(7))
                        0:       d[i] = '0;
                        1:       d[i] = '1;
                        default: d[i] = NBITS'($urandom);
                    endcase
                    if ($urandom_range(3) == 0) v[i] = 1'b1;
                end
            end
        end
        v = '0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
